// File: rtl/memory_port_arbiter_if.sv
// Bus bundle between the pipeline fetch/data ports, the shared memory, and the arbiter.
// The arbiter takes the slave view; the pipeline and memory together form the master view.
interface memory_port_arbiter_if;
   logic        fetchRequest;
   logic [31:0] fetchAddress;
   logic        fetchReady;
   logic [31:0] fetchData;

   logic        dataRead;
   logic        dataWrite;
   logic [31:0] dataAddress;
   logic [31:0] dataWriteData;
   logic        dataReady;
   logic [31:0] dataReadData;

   logic        busError;

   logic        memRequest;
   logic        memWriteEnable;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic [31:0] memReadData;
   logic        memAck;

   modport slave (
      input  fetchRequest, fetchAddress,
      input  dataRead, dataWrite, dataAddress, dataWriteData,
      input  memReadData, memAck,
      output fetchReady, fetchData,
      output dataReady, dataReadData,
      output busError,
      output memRequest, memWriteEnable, memAddress, memWriteData
   );

   modport master (
      output fetchRequest, fetchAddress,
      output dataRead, dataWrite, dataAddress, dataWriteData,
      output memReadData, memAck,
      input  fetchReady, fetchData,
      input  dataReady, dataReadData,
      input  busError,
      input  memRequest, memWriteEnable, memAddress, memWriteData
   );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one variable-latency single-port memory between the fetch and memory pipeline stages.
// Data has priority; a bounded streak of data grants keeps fetch from starving.
module memory_port_arbiter #(
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input logic                  clk,
   input logic                  reset,
   memory_port_arbiter_if.slave bus
);
   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
   localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BUSY_FETCH = 2'd1,
      BUSY_DATA  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [31:0]         mem_address_q, mem_address_d;
   logic                mem_write_enable_q, mem_write_enable_d;
   logic [31:0]         mem_write_data_q, mem_write_data_d;

   logic        data_req;
   logic        access_done;
   logic        fetch_ready;
   logic        data_ready;
   logic        bus_error;
   logic [31:0] fetch_data;
   logic [31:0] data_read_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= IDLE;
         streak_q           <= '0;
         timer_q            <= '0;
         mem_address_q      <= '0;
         mem_write_enable_q <= 1'b0;
         mem_write_data_q   <= '0;
      end else begin
         state_q            <= state_d;
         streak_q           <= streak_d;
         timer_q            <= timer_d;
         mem_address_q      <= mem_address_d;
         mem_write_enable_q <= mem_write_enable_d;
         mem_write_data_q   <= mem_write_data_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      streak_d           = streak_q;
      timer_d            = timer_q;
      mem_address_d      = mem_address_q;
      mem_write_enable_d = mem_write_enable_q;
      mem_write_data_d   = mem_write_data_q;
      fetch_ready        = 1'b0;
      data_ready         = 1'b0;
      bus_error          = 1'b0;
      fetch_data         = '0;
      data_read_data     = '0;

      data_req    = bus.dataRead | bus.dataWrite;
      access_done = bus.memAck || (timer_q == TIMER_LAST);

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (data_req && (!bus.fetchRequest || streak_q < STREAK_MAX)) begin
               state_d            = BUSY_DATA;
               mem_address_d      = bus.dataAddress;
               mem_write_enable_d = bus.dataWrite;
               mem_write_data_d   = bus.dataWriteData;
               // Streak only grows while fetch is actually being held off.
               if (!bus.fetchRequest) begin
                  streak_d = '0;
               end else if (streak_q != STREAK_MAX) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (bus.fetchRequest) begin
               state_d            = BUSY_FETCH;
               mem_address_d      = bus.fetchAddress;
               mem_write_enable_d = 1'b0;
               mem_write_data_d   = '0;
               streak_d           = '0;
            end
         end

         BUSY_FETCH, BUSY_DATA: begin
            if (access_done) begin
               state_d   = IDLE;
               timer_d   = '0;
               bus_error = !bus.memAck;
               if (state_q == BUSY_FETCH) begin
                  fetch_ready = 1'b1;
                  fetch_data  = bus.memAck ? bus.memReadData : 32'd0;
               end else begin
                  data_ready     = 1'b1;
                  data_read_data = (bus.memAck && !mem_write_enable_q) ? bus.memReadData : 32'd0;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Completion pulses are suppressed in a reset cycle so an aborted access never reports.
   assign bus.fetchReady     = fetch_ready & ~reset;
   assign bus.dataReady      = data_ready & ~reset;
   assign bus.busError       = bus_error & ~reset;
   assign bus.fetchData      = reset ? 32'd0 : fetch_data;
   assign bus.dataReadData   = reset ? 32'd0 : data_read_data;

   assign bus.memRequest     = (state_q != IDLE);
   assign bus.memWriteEnable = mem_write_enable_q;
   assign bus.memAddress     = mem_address_q;
   assign bus.memWriteData   = mem_write_data_q;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Random fetch/data requesters and a random-latency memory, checked each cycle
// against a transaction-level reference model of the arbitration rules.
module tb_memory_port_arbiter;
   localparam int MAX_STREAK = 4;
   localparam int TIMEOUT    = 8;
   localparam int NUM_CYCLES = 4000;
   localparam int NEVER      = 1000;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   memory_port_arbiter_if bus ();

   memory_port_arbiter #(
      .MAX_DATA_STREAK(MAX_STREAK),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: who owns the memory, how long it has owned it, fairness streak.
   int          m_owner;   // 0 none, 1 fetch, 2 data
   int          m_age;
   int          m_streak;
   logic [31:0] m_addr;
   logic        m_we;
   logic [31:0] m_wd;
   int          txn_count;

   // Requester agents and memory responder bookkeeping.
   logic f_done, d_done;
   logic mem_active;
   int   mem_cnt, mem_lat;

   logic        exp_busy, finish, exp_fr, exp_dr, exp_err;
   logic [31:0] exp_fd, exp_dd;

   initial begin
      reset                 = 1'b1;
      bus.fetchRequest      = 1'b0;
      bus.fetchAddress      = '0;
      bus.dataRead          = 1'b0;
      bus.dataWrite         = 1'b0;
      bus.dataAddress       = '0;
      bus.dataWriteData     = '0;
      bus.memReadData       = '0;
      bus.memAck            = 1'b0;
      f_done = 1'b0; d_done = 1'b0;
      mem_active = 1'b0; mem_cnt = 0; mem_lat = 0;
      m_owner = 0; m_age = 0; m_streak = 0; m_addr = '0; m_we = 1'b0; m_wd = '0;
      txn_count = 0;
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         reset = (cyc < 2) || ($urandom_range(0, 299) == 0);

         // Fetch agent: holds address until its ready, then maybe issues the next one.
         if (f_done) begin
            bus.fetchRequest = 1'b0;
            f_done = 1'b0;
         end
         if (!bus.fetchRequest && $urandom_range(0, 3) != 0) begin
            bus.fetchRequest = 1'b1;
            bus.fetchAddress = $urandom() & 32'hFFFF_FFFC;
         end

         // Data agent: loads, stores, and occasional read+write (treated as store).
         if (d_done) begin
            bus.dataRead  = 1'b0;
            bus.dataWrite = 1'b0;
            d_done = 1'b0;
         end
         if (!bus.dataRead && !bus.dataWrite && $urandom_range(0, 2) != 0) begin
            int kind;
            kind = $urandom_range(0, 7);
            bus.dataRead      = (kind < 4) || (kind == 7);
            bus.dataWrite     = (kind >= 4);
            bus.dataAddress   = $urandom() & 32'hFFFF_FFFC;
            bus.dataWriteData = $urandom();
         end

         // Memory: new latency per access, including timeout boundaries; stray acks when idle.
         if (!bus.memRequest) begin
            mem_active = 1'b0;
         end else if (!mem_active) begin
            int r;
            mem_active = 1'b1;
            mem_cnt    = 0;
            r = $urandom_range(0, 9);
            if (r <= 5)      mem_lat = $urandom_range(0, 3);
            else if (r == 6) mem_lat = TIMEOUT - 2;
            else if (r == 7) mem_lat = TIMEOUT - 1;
            else             mem_lat = NEVER;
         end
         bus.memAck      = mem_active ? (mem_cnt == mem_lat) : ($urandom_range(0, 3) == 0);
         bus.memReadData = $urandom();

         @(negedge clk);
         exp_busy = (m_owner != 0);
         finish   = exp_busy && (bus.memAck || m_age == TIMEOUT - 1);
         exp_fr   = !reset && (m_owner == 1) && finish;
         exp_dr   = !reset && (m_owner == 2) && finish;
         exp_err  = (exp_fr || exp_dr) && !bus.memAck;
         exp_fd   = (exp_fr && bus.memAck) ? bus.memReadData : 32'd0;
         exp_dd   = (exp_dr && bus.memAck && !m_we) ? bus.memReadData : 32'd0;

         check_value("memRequest",     32'(bus.memRequest),     32'(exp_busy));
         check_value("memAddress",     bus.memAddress,          m_addr);
         check_value("memWriteEnable", 32'(bus.memWriteEnable), 32'(m_we));
         check_value("memWriteData",   bus.memWriteData,        m_wd);
         check_value("fetchReady",     32'(bus.fetchReady),     32'(exp_fr));
         check_value("dataReady",      32'(bus.dataReady),      32'(exp_dr));
         check_value("busError",       32'(bus.busError),       32'(exp_err));
         check_value("fetchData",      bus.fetchData,           exp_fd);
         check_value("dataReadData",   bus.dataReadData,        exp_dd);

         if (bus.fetchReady) f_done = 1'b1;
         if (bus.dataReady)  d_done = 1'b1;
         if (mem_active) begin
            if (bus.memAck || mem_cnt >= TIMEOUT - 1) mem_active = 1'b0;
            else mem_cnt++;
         end

         // Advance the reference model across the coming clock edge.
         if (reset) begin
            m_owner = 0; m_age = 0; m_streak = 0;
            m_addr = '0; m_we = 1'b0; m_wd = '0;
         end else if (m_owner == 0) begin
            m_age = 0;
            if ((bus.dataRead || bus.dataWrite) && (!bus.fetchRequest || m_streak < MAX_STREAK)) begin
               m_owner  = 2;
               m_addr   = bus.dataAddress;
               m_we     = bus.dataWrite;
               m_wd     = bus.dataWriteData;
               m_streak = bus.fetchRequest ? ((m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1) : 0;
            end else if (bus.fetchRequest) begin
               m_owner  = 1;
               m_addr   = bus.fetchAddress;
               m_we     = 1'b0;
               m_wd     = '0;
               m_streak = 0;
            end
         end else if (finish) begin
            txn_count++;
            $display("txn %0d: %s addr=0x%08h we=%0b wait=%0d timeout=%0b", txn_count,
                     (m_owner == 1) ? "fetch" : "data ", m_addr, m_we, m_age, exp_err);
            m_owner = 0;
            m_age   = 0;
         end else begin
            m_age++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
